// File: rtl/lcd_write_sequencer.sv
// Sequences the 4-bit LCD nibble sender: power-up delay, init bytes, then client byte writes.
// Optional LCD_AUTOWRAP_EN: tracks column/line and inserts a line-change address write at column 16.
module lcd_write_sequencer #(
    parameter int POWERUP_CYCLES    = 750000,
    parameter int CLEAR_WAIT_CYCLES = 82000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iCharValid,
    input  logic [7:0] iChar,
    input  logic       iIsCmd,
    output logic       oCharReady,
    output logic       oInitDone,
    output logic       oWriteEnable,
    output logic [7:0] oData,
    output logic       oRS,
    input  logic       iWriteDone,
    output logic [2:0] dbg_state
);

    // Handshake: a request transfers on a rising edge where iCharValid && oCharReady;
    // oCharReady is high only in IDLE, so at most one request is taken per write.

    typedef enum logic [2:0] {
        S_POWERUP    = 3'd0,
        S_INIT_ISSUE = 3'd1,
        S_INIT_WAIT  = 3'd2,
        S_IDLE       = 3'd3,
        S_ISSUE      = 3'd4,
        S_LONG_WAIT  = 3'd5
`ifdef LCD_AUTOWRAP_EN
        , S_WRAP     = 3'd6
`endif
    } state_t;

    localparam logic [31:0] POWERUP_LAST = 32'(POWERUP_CYCLES - 1);
    localparam logic [31:0] CLEAR_LAST   = 32'(CLEAR_WAIT_CYCLES - 1);
    localparam logic [2:0]  INIT_COUNT   = 3'd6;

    state_t      state;
    state_t      next_state;
    logic [31:0] count;
    logic [2:0]  init_idx;
    logic [7:0]  char_q;
    logic        cmd_q;
    logic        accept;
    logic        is_home_cmd;

    logic        we_d;
    logic [7:0]  data_d;
    logic        rs_d;
    logic        ready_d;
    logic        init_done_d;

`ifdef LCD_AUTOWRAP_EN
    logic [4:0]  col;
    logic        line;
    logic        wrap_due;
`endif

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    init_byte = 8'h33;
            3'd1:    init_byte = 8'h32;
            3'd2:    init_byte = 8'h28;
            3'd3:    init_byte = 8'h06;
            3'd4:    init_byte = 8'h0C;
            3'd5:    init_byte = 8'h01;
            default: init_byte = 8'h00;
        endcase
    endfunction

    assign accept      = iCharValid && oCharReady;
    assign is_home_cmd = cmd_q && (char_q == 8'h01 || char_q == 8'h02 || char_q == 8'h03);
    assign dbg_state   = state;

`ifdef LCD_AUTOWRAP_EN
    // The data write now finishing moves the cursor onto column 16.
    assign wrap_due = !cmd_q && (col == 5'd15);
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= S_POWERUP;
            count <= '0;
        end else begin
            state <= next_state;
            count <= (next_state != state) ? '0 : count + 32'd1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_POWERUP:
                if (count == POWERUP_LAST) next_state = S_INIT_ISSUE;
            S_INIT_ISSUE:
                if (iWriteDone) next_state = S_INIT_WAIT;
            S_INIT_WAIT:
                if (init_idx != INIT_COUNT) next_state = S_INIT_ISSUE;
                else if (count == CLEAR_LAST) next_state = S_IDLE;
            S_IDLE:
                if (accept) next_state = S_ISSUE;
            S_ISSUE:
                if (iWriteDone) begin
                    if (is_home_cmd) next_state = S_LONG_WAIT;
`ifdef LCD_AUTOWRAP_EN
                    else if (wrap_due) next_state = S_WRAP;
`endif
                    else next_state = S_IDLE;
                end
            S_LONG_WAIT:
                if (count == CLEAR_LAST) next_state = S_IDLE;
`ifdef LCD_AUTOWRAP_EN
            S_WRAP:
                if (iWriteDone) next_state = S_IDLE;
`endif
            default:
                next_state = S_POWERUP;
        endcase
    end

    // Outputs are registered from the next state, so enable drops on the edge that sees done.
    always_comb begin
        we_d        = 1'b0;
        data_d      = 8'h00;
        rs_d        = 1'b0;
        ready_d     = (next_state == S_IDLE);
        init_done_d = oInitDone || (next_state == S_IDLE);
        case (next_state)
            S_INIT_ISSUE: begin
                we_d   = 1'b1;
                data_d = init_byte(init_idx);
            end
            S_ISSUE: begin
                we_d   = 1'b1;
                data_d = (state == S_IDLE) ? iChar : char_q;
                rs_d   = (state == S_IDLE) ? !iIsCmd : !cmd_q;
            end
`ifdef LCD_AUTOWRAP_EN
            S_WRAP: begin
                we_d   = 1'b1;
                data_d = line ? 8'h80 : 8'hC0;
            end
`endif
            default: begin
                we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            oWriteEnable <= 1'b0;
            oData        <= 8'h00;
            oRS          <= 1'b0;
            oCharReady   <= 1'b0;
            oInitDone    <= 1'b0;
            init_idx     <= '0;
            char_q       <= 8'h00;
            cmd_q        <= 1'b0;
`ifdef LCD_AUTOWRAP_EN
            col          <= '0;
            line         <= 1'b0;
`endif
        end else begin
            oWriteEnable <= we_d;
            oData        <= data_d;
            oRS          <= rs_d;
            oCharReady   <= ready_d;
            oInitDone    <= init_done_d;
            if (state == S_INIT_ISSUE && iWriteDone) init_idx <= init_idx + 3'd1;
            if (state == S_IDLE && accept) begin
                char_q <= iChar;
                cmd_q  <= iIsCmd;
            end
`ifdef LCD_AUTOWRAP_EN
            if (state == S_ISSUE && iWriteDone) begin
                if (is_home_cmd) begin
                    col  <= '0;
                    line <= 1'b0;
                end else if (!cmd_q) begin
                    col <= col + 5'd1;
                end
            end
            if (state == S_WRAP && iWriteDone) begin
                col  <= '0;
                line <= !line;
            end
`endif
        end
    end

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Bench for lcd_write_sequencer: sender model, write-log scoreboard, timing and reset checks.
`timescale 1ns/1ps
module tb_lcd_write_sequencer;

    localparam int PU       = 20;
    localparam int CW       = 10;
    localparam int DONE_LAT = 5;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       iCharValid;
    logic [7:0] iChar;
    logic       iIsCmd;
    logic       oCharReady;
    logic       oInitDone;
    logic       oWriteEnable;
    logic [7:0] oData;
    logic       oRS;
    logic       iWriteDone;
    logic [2:0] dbg_state;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_edge = 0;
    int en_cnt = 0;
    bit stray_req = 1'b0;
    logic [8:0] hold_byte;
    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];
    int  col = 0;
    bit  line = 1'b0;

    lcd_write_sequencer #(
        .POWERUP_CYCLES(PU),
        .CLEAR_WAIT_CYCLES(CW)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .iCharValid(iCharValid),
        .iChar(iChar),
        .iIsCmd(iIsCmd),
        .oCharReady(oCharReady),
        .oInitDone(oInitDone),
        .oWriteEnable(oWriteEnable),
        .oData(oData),
        .oRS(oRS),
        .iWriteDone(iWriteDone),
        .dbg_state(dbg_state)
    );

    always #10 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Sender model: logs each write at enable rise, pulses done DONE_LAT cycles later.
    initial begin
        iWriteDone = 1'b0;
        forever begin
            @(negedge Clock);
            iWriteDone = 1'b0;
            if (oWriteEnable) begin
                if (en_cnt == 0) begin
                    obs_q.push_back({oRS, oData});
                    hold_byte = {oRS, oData};
                end else begin
                    check("data_stable", 32'({oRS, oData}), 32'(hold_byte));
                end
                en_cnt++;
                if (en_cnt == DONE_LAT) begin
                    iWriteDone = 1'b1;
                    done_edge  = cyc + 1;
                    en_cnt     = 0;
                end
            end else begin
                en_cnt = 0;
                if (stray_req) begin
                    iWriteDone = 1'b1;
                    stray_req  = 1'b0;
                end
            end
        end
    end

    // Reference: every accepted request is one write; wrap inserts an address write at column 16.
    task automatic model_accept(input logic [7:0] ch, input logic cmd, output bit is_long);
        is_long = cmd && (ch >= 8'h01) && (ch <= 8'h03);
        exp_q.push_back({!cmd, ch});
`ifdef LCD_AUTOWRAP_EN
        if (is_long) begin
            col  = 0;
            line = 1'b0;
        end else if (!cmd) begin
            col++;
            if (col == 16) begin
                exp_q.push_back({1'b0, line ? 8'h80 : 8'hC0});
                line = !line;
                col  = 0;
            end
        end
`endif
    endtask

    task automatic push_init;
        logic [7:0] seq [6] = '{8'h33, 8'h32, 8'h28, 8'h06, 8'h0C, 8'h01};
        foreach (seq[i]) exp_q.push_back({1'b0, seq[i]});
    endtask

    task automatic apply_reset(input int cycles);
        Reset = 1'b1;
        repeat (cycles) @(negedge Clock);
        check("rst_we", oWriteEnable, 1'b0);
        check("rst_data", oData, 8'h00);
        check("rst_rs", oRS, 1'b0);
        check("rst_ready", oCharReady, 1'b0);
        check("rst_init_done", oInitDone, 1'b0);
        Reset = 1'b0;
        col  = 0;
        line = 1'b0;
    endtask

    task automatic check_powerup;
        int n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (!oWriteEnable && n < 200);
        check("powerup_len", n, PU);
    endtask

    task automatic wait_init;
        int n = 0;
        while (!oInitDone && n < 500) begin
            @(negedge Clock);
            n++;
        end
        check("init_done_seen", oInitDone, 1'b1);
        check("init_done_delay", cyc - done_edge, CW);
        check("ready_after_init", oCharReady, 1'b1);
    endtask

    task automatic send_req(input logic [7:0] ch, input logic cmd, output bit is_long);
        int n = 0;
        while (!oCharReady && n < 500) begin
            @(negedge Clock);
            n++;
        end
        check("req_ready", oCharReady, 1'b1);
        iCharValid = 1'b1;
        iChar      = ch;
        iIsCmd     = cmd;
        @(negedge Clock);
        iCharValid = 1'b0;
        check("req_we", oWriteEnable, 1'b1);
        check("req_data", oData, ch);
        check("req_rs", oRS, !cmd);
        check("req_ready_drop", oCharReady, 1'b0);
        model_accept(ch, cmd, is_long);
    endtask

    task automatic finish_req(input int delay);
        int n = 0;
        while (!oCharReady && n < 500) begin
            @(negedge Clock);
            n++;
        end
        check("ready_back", oCharReady, 1'b1);
        check("ready_delay", cyc - done_edge, delay);
    endtask

    task automatic compare_log(input string tag);
        logic [8:0] e;
        logic [8:0] o;
        check(tag, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 9'h1FF;
            check(tag, 32'(o), 32'(e));
        end
        obs_q.delete();
    endtask

    initial begin
        bit         lng;
        logic [7:0] ch;
        logic       cmd;
        logic [7:0] cmd_tab [6] = '{8'h01, 8'h02, 8'h03, 8'h0C, 8'h80, 8'h18};
        int         n;

        Reset      = 1'b1;
        iCharValid = 1'b0;
        iChar      = 8'h00;
        iIsCmd     = 1'b0;

        apply_reset(3);
        check_powerup();
        push_init();
        wait_init();
        compare_log("init_log");

        send_req(8'h41, 1'b0, lng);
        finish_req(0);
        send_req(8'h01, 1'b1, lng);
        finish_req(CW);

        // Request held valid through a busy write: taken exactly once afterwards.
        send_req(8'h20, 1'b0, lng);
        iCharValid = 1'b1;
        iChar      = 8'h42;
        iIsCmd     = 1'b0;
        n = 0;
        while (!oCharReady && n < 500) begin
            @(negedge Clock);
            n++;
        end
        check("hold_ready", oCharReady, 1'b1);
        @(negedge Clock);
        iCharValid = 1'b0;
        check("hold_we", oWriteEnable, 1'b1);
        check("hold_data", oData, 8'h42);
        model_accept(8'h42, 1'b0, lng);
        finish_req(0);

        stray_req = 1'b1;
        repeat (4) @(negedge Clock);
        check("stray_we", oWriteEnable, 1'b0);
        check("stray_ready", oCharReady, 1'b1);
        compare_log("directed_log");

        for (int i = 0; i < 30; i++) begin
            cmd = ($urandom_range(0, 3) == 0);
            ch  = cmd ? cmd_tab[$urandom_range(0, 5)] : 8'($urandom_range(8'h20, 8'h7E));
            send_req(ch, cmd, lng);
            finish_req(lng ? CW : 0);
        end
        compare_log("random_log");

        send_req(8'h01, 1'b1, lng);
        finish_req(CW);
        for (int i = 0; i < 33; i++) begin
            send_req(8'($urandom_range(8'h30, 8'h5A)), 1'b0, lng);
            finish_req(0);
        end
        compare_log("wrap_log");

        send_req(8'h55, 1'b0, lng);
        apply_reset(1);
        check_powerup();
        push_init();
        wait_init();
        compare_log("reset_log");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
